// File: rtl/dadda_mul_pipe_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dadda_mul_pipe_if : operand/result stream bundle for the Dadda mul |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
interface dadda_mul_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 2 * WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic                 approx_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 overflow;
  logic                 approx_out;

  modport master (
    output in_valid, in1, in2, approx_en, out_ready,
    input  in_ready, out_valid, out, overflow, approx_out
  );

  modport slave (
    input  in_valid, in1, in2, approx_en, out_ready,
    output in_ready, out_valid, out, overflow, approx_out
  );
endinterface
`default_nettype wire

// File: rtl/dadda_mul_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dadda_mul_pipe : pipelined unsigned Dadda multiplier, approx mode  |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module dadda_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int OUT_WIDTH   = 2 * WIDTH,
  parameter int PIPE_STAGES = 2,
  parameter int APPROX_COLS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dadda_mul_pipe_if.slave bus
);

  localparam int c_PW   = 2 * WIDTH;
  localparam int c_POOL = 2 * WIDTH;

  function automatic int dadda_d(input int k);
    int d;
    d = 2;
    for (int i = 0; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int dadda_levels(input int w);
    int n;
    n = 0;
    for (int k = 0; k < 32; k++) if (dadda_d(k) < w) n = k + 1;
    return n;
  endfunction

  localparam int c_LEVELS = dadda_levels(WIDTH);

  logic [c_PW-1:0]        w_row_a, w_row_b, w_prod;
  logic                   w_ovf;
  logic                   w_advance;
  logic [PIPE_STAGES-1:0] r_vld, r_apx;
  logic [c_PW-1:0]        r_row_a [PIPE_STAGES];
  logic [c_PW-1:0]        r_row_b [PIPE_STAGES];

  // Columns shrink to successive Dadda heights; carries land in the next column's next-level pool.
  always_comb begin : p_reduce
    logic [c_POOL-1:0] col [c_PW];
    logic [c_POOL-1:0] nxt [c_PW];
    int                h   [c_PW];
    int                nh  [c_PW];
    int                n, p, d;
    logic              x0, x1, x2;
    n = 0; p = 0; d = 0;
    x0 = 1'b0; x1 = 1'b0; x2 = 1'b0;
    for (int c = 0; c < c_PW; c++) begin
      col[c] = '0; nxt[c] = '0; h[c] = 0; nh[c] = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][h[i+j]] = (bus.approx_en && (i + j < APPROX_COLS)) ? 1'b0
                                                                    : (bus.in1[j] & bus.in2[i]);
        h[i+j] = h[i+j] + 1;
      end
    end
    for (int k = c_LEVELS - 1; k >= 0; k--) begin
      d = dadda_d(k);
      for (int c = 0; c < c_PW; c++) begin
        nxt[c] = '0; nh[c] = 0;
      end
      for (int c = 0; c < c_PW; c++) begin
        n = h[c] + nh[c];
        p = 0;
        for (int t = 0; t < c_POOL; t++) begin
          if (n > d && p + 1 < h[c]) begin
            x0 = col[c][p];
            x1 = col[c][p+1];
            if (n - d >= 2 && p + 2 < h[c]) begin
              x2 = col[c][p+2];
              nxt[c][nh[c]] = x0 ^ x1 ^ x2;
              if (c + 1 < c_PW) begin
                nxt[c+1][nh[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                nh[c+1] = nh[c+1] + 1;
              end
              p = p + 3;
              n = n - 2;
            end else begin
              nxt[c][nh[c]] = x0 ^ x1;
              if (c + 1 < c_PW) begin
                nxt[c+1][nh[c+1]] = x0 & x1;
                nh[c+1] = nh[c+1] + 1;
              end
              p = p + 2;
              n = n - 1;
            end
            nh[c] = nh[c] + 1;
          end
        end
        for (int t = 0; t < c_POOL; t++) begin
          if (t >= p && t < h[c]) begin
            nxt[c][nh[c]] = col[c][t];
            nh[c] = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < c_PW; c++) begin
        col[c] = nxt[c]; h[c] = nh[c];
      end
    end
    for (int c = 0; c < c_PW; c++) begin
      w_row_a[c] = col[c][0];
      w_row_b[c] = col[c][1];
    end
  end

  assign w_advance = !r_vld[PIPE_STAGES-1] || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_apx <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_row_a[s] <= '0;
        r_row_b[s] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0] <= bus.in_valid;
      if (bus.in_valid) begin
        r_apx[0]   <= bus.approx_en;
        r_row_a[0] <= w_row_a;
        r_row_b[0] <= w_row_b;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_vld[s]   <= r_vld[s-1];
        r_apx[s]   <= r_apx[s-1];
        r_row_a[s] <= r_row_a[s-1];
        r_row_b[s] <= r_row_b[s-1];
      end
    end
  end

  // Kogge-Stone carry-lookahead merges the two surviving rows after the last stage.
  always_comb begin : p_cla
    logic [c_PW-1:0] g, pr, gn, pn, x;
    x  = r_row_a[PIPE_STAGES-1] ^ r_row_b[PIPE_STAGES-1];
    g  = r_row_a[PIPE_STAGES-1] & r_row_b[PIPE_STAGES-1];
    pr = x;
    for (int s = 1; s < c_PW; s = s * 2) begin
      gn = g;
      pn = pr;
      for (int i = 0; i < c_PW; i++) begin
        if (i >= s) begin
          gn[i] = g[i] | (pr[i] & g[i-s]);
          pn[i] = pr[i] & pr[i-s];
        end
      end
      g  = gn;
      pr = pn;
    end
    w_prod = x ^ {g[c_PW-2:0], 1'b0};
  end

  generate
    if (OUT_WIDTH < c_PW) begin : g_ovf
      assign w_ovf = |w_prod[c_PW-1:OUT_WIDTH];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign bus.in_ready   = w_advance;
  assign bus.out_valid  = r_vld[PIPE_STAGES-1];
  assign bus.approx_out = r_apx[PIPE_STAGES-1];
  assign bus.out        = w_prod[OUT_WIDTH-1:0];
  assign bus.overflow   = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dadda_mul_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_dadda_mul_pipe : full-width and truncated-width DUTs in lockstep |
// | rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_dadda_mul_pipe;
  localparam int WIDTH   = 6;
  localparam int FULL_W  = 12;
  localparam int SMALL_W = 10;
  localparam int STAGES  = 2;
  localparam int COLS    = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             approx_en;
  logic             out_ready;
  logic [WIDTH-1:0] in1, in2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int first_out_cyc = 0;
  int last_out_cyc = 0;

  typedef struct {
    int p;
    bit apx;
  } exp_t;
  exp_t sb[$];

  dadda_mul_pipe_if #(.WIDTH(WIDTH), .OUT_WIDTH(FULL_W))  bf ();
  dadda_mul_pipe_if #(.WIDTH(WIDTH), .OUT_WIDTH(SMALL_W)) bo ();

  assign bf.in_valid  = in_valid;
  assign bf.in1       = in1;
  assign bf.in2       = in2;
  assign bf.approx_en = approx_en;
  assign bf.out_ready = out_ready;
  assign bo.in_valid  = in_valid;
  assign bo.in1       = in1;
  assign bo.in2       = in2;
  assign bo.approx_en = approx_en;
  assign bo.out_ready = out_ready;

  dadda_mul_pipe #(.WIDTH(WIDTH), .OUT_WIDTH(FULL_W), .PIPE_STAGES(STAGES), .APPROX_COLS(COLS))
    dut_full (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  dadda_mul_pipe #(.WIDTH(WIDTH), .OUT_WIDTH(SMALL_W), .PIPE_STAGES(STAGES), .APPROX_COLS(COLS))
    dut_small (.clk(clk), .rst_n(rst_n), .bus(bo.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact mode is a plain product; approximate mode sums only the bit pairs whose weight index reaches COLS.
  function automatic int ref_prod(input int a, input int b, input bit apx);
    int p;
    if (!apx) return a * b;
    p = 0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if ((((a >> j) & 1) == 1) && (((b >> i) & 1) == 1) && (i + j >= COLS))
          p += (1 << (i + j));
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bf.out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("sb_out",        bf.out, e.p);
          check("sb_approx_out", bf.approx_out, e.apx);
          check("sb_overflow",   bf.overflow, 0);
          check("sb_small_valid", bo.out_valid, 1);
          check("sb_small_out",  bo.out, e.p % 1024);
          check("sb_small_ovf",  bo.overflow, (e.p >= 1024) ? 1 : 0);
          if (n_out == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          n_out++;
        end
      end
      if (in_valid === 1'b1 && bf.in_ready === 1'b1)
        sb.push_back('{ref_prod(int'(in1), int'(in2), approx_en), approx_en});
    end
  end

  task automatic single(input int a, input int b, input bit apx,
                        input int exp_full, input int exp_small, input bit exp_ovf);
    in1 = a[WIDTH-1:0];
    in2 = b[WIDTH-1:0];
    approx_en = apx;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early_valid", bf.out_valid, 0);
    @(negedge clk);
    check("lat_valid",      bf.out_valid, 1);
    check("dir_out",        bf.out, exp_full);
    check("dir_approx_out", bf.approx_out, apx);
    check("dir_small_out",  bo.out, exp_small);
    check("dir_small_ovf",  bo.overflow, exp_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_rdy [10];
    bit exp_ov  [10];
    logic [WIDTH-1:0] pa [3];
    logic [WIDTH-1:0] pb [3];
    bit px [3];
    int idx;

    rst_n = 1'b0;
    in_valid = 1'b1;
    in1 = 6'd63;
    in2 = 6'd63;
    approx_en = 1'b0;
    out_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", bf.out_valid, 0);
      check("rst_out",       bf.out, 0);
      check("rst_overflow",  bo.overflow, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bf.in_ready, 1);
    @(posedge clk); #1;

    single(63, 63, 1'b0, 3969, 897, 1'b1);
    single(63, 63, 1'b1, 3920, 848, 1'b1);
    single(5, 3, 1'b1, 0, 0, 1'b0);
    single(31, 33, 1'b0, 1023, 1023, 1'b0);

    n_out = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in1 = 6'($urandom_range(0, 63));
      in2 = 6'($urandom_range(0, 63));
      approx_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (STAGES + 1) @(posedge clk);
    #1;
    check("burst_count",       n_out, 20);
    check("burst_consecutive", last_out_cyc - first_out_cyc, 19);

    exp_rdy = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    exp_ov  = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      pa[k] = 6'($urandom_range(0, 63));
      pb[k] = 6'($urandom_range(0, 63));
      px[k] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    n_out = 0;
    for (int t = 0; t < 10; t++) begin
      out_ready = (t >= 5);
      in_valid = (idx < 3);
      if (idx < 3) begin
        in1 = pa[idx];
        in2 = pb[idx];
        approx_en = px[idx];
      end
      @(negedge clk);
      check("bp_in_ready",  bf.in_ready, exp_rdy[t]);
      check("bp_out_valid", bf.out_valid, exp_ov[t]);
      if (t >= 2 && t <= 5)
        check("bp_hold_out", bf.out, ref_prod(int'(pa[0]), int'(pb[0]), px[0]));
      if (in_valid && bf.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", idx, 3);
    check("bp_count",    n_out, 3);

    out_ready = 1'b0;
    in1 = 6'd7;
    in2 = 6'd9;
    approx_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_stall_valid",    bf.out_valid, 0);
    check("rst_stall_out",      bf.out, 0);
    check("rst_stall_in_ready", bf.in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    single(12, 10, 1'b0, 120, 120, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
